// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, FSM encoding, inverse S-box and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int AES_NB  = 4;
  localparam int AES_NK  = 4;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 32 * AES_NB * (AES_NR + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Only 4-bit coefficients are needed for InvMixColumns (0e/0b/0d/09).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round import aes_pkg::*; (
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               is_final,
  output logic [BLOCK_W-1:0] next
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[7:0];
    s1 = c[15:8];
    s2 = c[23:16];
    s3 = c[31:24];
    return {gmul(s0, 4'hb) ^ gmul(s1, 4'hd) ^ gmul(s2, 4'h9) ^ gmul(s3, 4'he),
            gmul(s0, 4'hd) ^ gmul(s1, 4'h9) ^ gmul(s2, 4'he) ^ gmul(s3, 4'hb),
            gmul(s0, 4'h9) ^ gmul(s1, 4'he) ^ gmul(s2, 4'hb) ^ gmul(s3, 4'hd),
            gmul(s0, 4'he) ^ gmul(s1, 4'hb) ^ gmul(s2, 4'hd) ^ gmul(s3, 4'h9)};
  endfunction

  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] added;
  logic [BLOCK_W-1:0] mixed;

  always_comb begin
    shifted = '0;
    added   = '0;
    mixed   = '0;
    // Row r rotates right by r columns: new (r,c) takes old (r, c-r mod 4).
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[8*(4*c+r) +: 8] = state[8*(4*((c - r + 4) % 4) + r) +: 8];
      end
    end
    for (int j = 0; j < 16; j++) begin
      added[8*j +: 8] = INV_SBOX[shifted[8*j +: 8]] ^ round_key[8*j +: 8];
    end
    for (int c = 0; c < AES_NB; c++) begin
      mixed[32*c +: 32] = inv_mix_col(added[32*c +: 32]);
    end
    next = is_final ? added : mixed;
  end

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready in and out.
// Define AES_INV_KEY_LATCH_EN to capture w on accept so it may change during the rounds.
//
// state | meaning
// IDLE  | waiting for a ciphertext block, in_ready=1
// ROUND | rounds 9..0 in progress, busy=1, input ignored
// DONE  | plaintext held on out until the consumer takes it
module aes_inv_cipher_seq import aes_pkg::*; #(
  parameter int NR        = AES_NR,
  parameter int KEY_WORDS = AES_NB * (AES_NR + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_W-1:0]      in,
  input  logic [32*KEY_WORDS-1:0] w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_W-1:0]      out,
  output logic                    busy
);

  logic [1:0]              fsm_q, fsm_d;
  logic [3:0]              rnd_q, rnd_d;
  logic [BLOCK_W-1:0]      state_q, state_d;
  logic [BLOCK_W-1:0]      rk;
  logic [BLOCK_W-1:0]      round_out;
  logic [32*KEY_WORDS-1:0] key_src;
  logic                    accept;

  assign in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_ROUND);
  assign out       = state_q;

`ifdef AES_INV_KEY_LATCH_EN
  logic [32*KEY_WORDS-1:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (accept) key_d = w;
  end

  always_ff @(posedge clk) begin
    if (rst) key_q <= '0;
    else     key_q <= key_d;
  end

  assign key_src = key_q;
`else
  assign key_src = w;
`endif

  always_comb begin
    rk = '0;
    for (int r = 0; r <= NR; r++) begin
      if (rnd_q == r[3:0]) rk = key_src[128*r +: 128];
    end
  end

  aes_inv_round u_round (
    .state     (state_q),
    .round_key (rk),
    .is_final  (rnd_q == 4'd0),
    .next      (round_out)
  );

  // The initial AddRoundKey with rk10 is folded into the accept edge, always from live w.
  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = in ^ w[128*NR +: 128];
          rnd_d   = 4'(NR - 1);
          fsm_d   = ST_ROUND;
        end else if ((fsm_q == ST_DONE) && out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        if (rnd_q == 4'd0) fsm_d = ST_DONE;
        else               rnd_d = rnd_q - 4'd1;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

endmodule
